// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format constants, error bit indices and range/alignment check helpers.
// Decode helper exists only when IMM_ENC_ROUNDTRIP_CHECK_EN is defined.
package imm_pkg;

    localparam logic [4:0] IMM_SEL_R      = 5'd0;
    localparam logic [4:0] IMM_SEL_S      = 5'd1;
    localparam logic [4:0] IMM_SEL_B      = 5'd2;
    localparam logic [4:0] IMM_SEL_U      = 5'd3;
    localparam logic [4:0] IMM_SEL_J      = 5'd4;
    localparam logic [4:0] IMM_SEL_I      = 5'd5;
    localparam logic [4:0] IMM_SEL_I_STAR = 5'd6;

    localparam int unsigned ERR_RANGE = 0;
    localparam int unsigned ERR_ALIGN = 1;
    localparam int unsigned ERR_SEL   = 2;

    // Signed formats are legal when imm is the sign-extension of its low K bits.
    localparam int unsigned IMM_K_I      = 12;
    localparam int unsigned IMM_K_B      = 13;
    localparam int unsigned IMM_K_J      = 21;
    localparam int unsigned IMM_K_I_STAR = 5;

    function automatic logic fits_signed(input logic [31:0] imm, input int unsigned k);
        logic [31:0] m;
        m = '1 << (k - 1);
        return ((imm & m) == '0) || ((imm & m) == m);
    endfunction

    function automatic logic [2:0] imm_errors(input logic [4:0] sel, input logic [31:0] imm);
        logic [2:0] e;
        e = '0;
        case (sel)
            IMM_SEL_R: ;
            IMM_SEL_I, IMM_SEL_S: e[ERR_RANGE] = !fits_signed(imm, IMM_K_I);
            IMM_SEL_B: begin
                e[ERR_RANGE] = !fits_signed(imm, IMM_K_B);
                e[ERR_ALIGN] = imm[0];
            end
            IMM_SEL_J: begin
                e[ERR_RANGE] = !fits_signed(imm, IMM_K_J);
                e[ERR_ALIGN] = imm[0];
            end
            IMM_SEL_U:      e[ERR_ALIGN] = |imm[11:0];
            IMM_SEL_I_STAR: e[ERR_RANGE] = |(imm >> IMM_K_I_STAR);
            default:        e[ERR_SEL] = 1'b1;
        endcase
        return e;
    endfunction

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    function automatic logic [31:0] imm_decode(input logic [4:0] sel, input logic [31:0] inst);
        logic [31:0] v;
        v = '0;
        case (sel)
            IMM_SEL_I:      v = {{20{inst[31]}}, inst[31:20]};
            IMM_SEL_I_STAR: v = {27'd0, inst[24:20]};
            IMM_SEL_S:      v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_SEL_B:      v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_SEL_U:      v = {inst[31:12], 12'd0};
            IMM_SEL_J:      v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:        v = '0;
        endcase
        return v;
    endfunction
`endif

endpackage

// File: rtl/imm_encoder_field_pack.sv
// Combinational scatter of an immediate into the bit fields of the selected instruction format.
module imm_field_pack
    import imm_pkg::*;
(
    input  logic [31:0] tmpl_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  sel_i,
    output logic [31:0] inst_o
);

    always_comb begin
        inst_o = tmpl_i;
        case (sel_i)
            IMM_SEL_I:      inst_o[31:20] = imm_i[11:0];
            IMM_SEL_I_STAR: inst_o[24:20] = imm_i[4:0];
            IMM_SEL_S: begin
                inst_o[31:25] = imm_i[11:5];
                inst_o[11:7]  = imm_i[4:0];
            end
            IMM_SEL_B: begin
                inst_o[31]    = imm_i[12];
                inst_o[7]     = imm_i[11];
                inst_o[30:25] = imm_i[10:5];
                inst_o[11:8]  = imm_i[4:1];
            end
            IMM_SEL_U:      inst_o[31:12] = imm_i[31:12];
            IMM_SEL_J: begin
                inst_o[31]    = imm_i[20];
                inst_o[30:21] = imm_i[10:1];
                inst_o[20]    = imm_i[11];
                inst_o[19:12] = imm_i[19:12];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: S1 registers request + error bits, S2 registers packed word.
// Optional IMM_ENC_ROUNDTRIP_CHECK_EN adds rt_mismatch, a registered re-decode self-check.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_tmpl,
    input  logic [31:0]      in_imm,
    input  logic [4:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [2:0]       out_err,
    output logic [CNT_W-1:0] err_count
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    ,
    output logic             rt_mismatch
`endif
);

    logic             s1_valid_q;
    logic [31:0]      s1_tmpl_q;
    logic [31:0]      s1_imm_q;
    logic [4:0]       s1_sel_q;
    logic [2:0]       s1_err_q;
    logic             s2_valid_q;
    logic [31:0]      s2_inst_q;
    logic [2:0]       s2_err_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [2:0]  err_d;
    logic [31:0] packed_w;
    logic [31:0] inst_d;
    logic        s1_adv;
    logic        s2_adv;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb err_d = imm_errors(in_sel, in_imm);

    imm_field_pack u_pack (
        .tmpl_i (s1_tmpl_q),
        .imm_i  (s1_imm_q),
        .sel_i  (s1_sel_q),
        .inst_o (packed_w)
    );

    // Any error leaves the template untouched so a rejected request is recognisable downstream.
    always_comb inst_d = (s1_err_q != '0) ? s1_tmpl_q : packed_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tmpl_q  <= '0;
            s1_imm_q   <= '0;
            s1_sel_q   <= '0;
            s1_err_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= '0;
            s2_err_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_tmpl_q <= in_tmpl;
                    s1_imm_q  <= in_imm;
                    s1_sel_q  <= in_sel;
                    s1_err_q  <= err_d;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_inst_q <= inst_d;
                    s2_err_q  <= s1_err_q;
                end
            end
            if (s2_valid_q && out_ready && (s2_err_q != '0) && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign err_count = err_cnt_q;

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    logic rt_q;
    logic rt_d;

    always_comb rt_d = (s1_err_q == '0) && (s1_sel_q != IMM_SEL_R) &&
                       (imm_decode(s1_sel_q, inst_d) != s1_imm_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rt_q <= 1'b0;
        end else if (s2_adv && s1_valid_q) begin
            rt_q <= rt_d;
        end
    end

    assign rt_mismatch = rt_q;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: bit-map reference model, per-cycle scoreboard, directed vectors.
module tb_imm_encoder;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_tmpl = '0;
    logic [31:0]      in_imm = '0;
    logic [4:0]       in_sel = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_inst;
    logic [2:0]       out_err;
    logic [CNT_W-1:0] err_count;
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    logic             rt_mismatch;
`endif

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tmpl   (in_tmpl),
        .in_imm    (in_imm),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .err_count (err_count)
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
        ,
        .rt_mismatch (rt_mismatch)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;

    task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Which immediate bit lands in instruction bit p for a format (-1: template bit).
    function automatic int src_bit(input int sel, input int p);
        case (sel)
            5: return (p >= 20) ? p - 20 : -1;
            6: return (p >= 20 && p <= 24) ? p - 20 : -1;
            1: return (p >= 25) ? p - 20 : (p >= 7 && p <= 11) ? p - 7 : -1;
            2: return (p == 31) ? 12 : (p >= 25) ? p - 20 : (p >= 8 && p <= 11) ? p - 7 :
                      (p == 7) ? 11 : -1;
            3: return (p >= 12) ? p : -1;
            4: return (p == 31) ? 20 : (p >= 21) ? p - 20 : (p == 20) ? 11 :
                      (p >= 12) ? p : -1;
            default: return -1;
        endcase
    endfunction

    function automatic logic [34:0] model(input logic [4:0] sel, input logic [31:0] tmpl,
                                          input logic [31:0] imm);
        int si;
        logic [2:0] e;
        logic [31:0] w;
        si = $signed(imm);
        e = '0;
        case (int'(sel))
            0: ;
            1, 5: e[0] = (si < -2048) || (si > 2047);
            2: begin e[0] = (si < -4096) || (si > 4095); e[1] = (imm % 2) != 0; end
            3: e[1] = (imm % 4096) != 0;
            4: begin e[0] = (si < -1048576) || (si > 1048575); e[1] = (imm % 2) != 0; end
            6: e[0] = imm > 31;
            default: e = 3'b100;
        endcase
        w = tmpl;
        if (e == 3'b000) begin
            for (int p = 0; p < 32; p++) begin
                int b;
                b = src_bit(int'(sel), p);
                if (b >= 0) w[p] = imm[b];
            end
        end
        return {e, w};
    endfunction

    typedef struct {
        logic [34:0] exp;
        int          acc;
    } item_t;
    item_t q[$];
    int unsigned mcnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcnt = 0;
            chk("rst_out_valid", 35'(out_valid), 35'd0);
            chk("rst_out", {out_err, out_inst}, 35'd0);
            chk("rst_err_count", 35'(err_count), 35'd0);
            chk("rst_in_ready", 35'(in_ready), 35'd1);
        end else begin
            logic exp_v;
            item_t it;
            exp_v = (q.size() > 0) && (cyc - q[0].acc >= 2);
            chk("out_valid", 35'(out_valid), 35'(exp_v));
            chk("in_ready", 35'(in_ready), 35'((q.size() < 2) || out_ready));
            chk("err_count", 35'(err_count), 35'(mcnt));
            if (out_valid && exp_v) begin
                chk("out_data", {out_err, out_inst}, q[0].exp);
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
                chk("rt_mismatch", 35'(rt_mismatch), 35'd0);
`endif
                if (out_ready) begin
                    if (q[0].exp[34:32] != 3'b000 && mcnt < (2 ** CNT_W) - 1) mcnt++;
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                it.exp = model(in_sel, in_tmpl, in_imm);
                it.acc = cyc;
                q.push_back(it);
            end
        end
    end

    task automatic push(input logic [4:0] sel, input logic [31:0] tmpl, input logic [31:0] imm);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_tmpl  = tmpl;
        in_imm   = imm;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 35'(ok), 35'd1);
        else n_acc++;
    endtask

    task automatic send_one(input logic [4:0] sel, input logic [31:0] tmpl, input logic [31:0] imm,
                            input logic [31:0] exp_inst, input logic [2:0] exp_err);
        int n;
        logic seen;
        push(sel, tmpl, imm);
        in_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = out_valid;
        end
        chk("latency", 35'(n), 35'd2);
        chk("lit_out", {out_err, out_inst}, {exp_err, exp_inst});
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] tmpl;
        logic [31:0] imm;
        logic [31:0] inst;
        logic [2:0]  err;
    } vec_t;

    vec_t vecs[13] = '{
        '{5'd2, 32'h00000063, 32'hFFFFFFFC, 32'hFE000EE3, 3'b000},
        '{5'd5, 32'h00000013, 32'h000007FF, 32'h7FF00013, 3'b000},
        '{5'd5, 32'h00000013, 32'h00000800, 32'h00000013, 3'b001},
        '{5'd4, 32'h0000006F, 32'h00000800, 32'h0010006F, 3'b000},
        '{5'd3, 32'h00000037, 32'h12345000, 32'h12345037, 3'b000},
        '{5'd3, 32'h00000037, 32'h12345001, 32'h00000037, 3'b010},
        '{5'd6, 32'h40005013, 32'h00000005, 32'h40505013, 3'b000},
        '{5'd6, 32'h40005013, 32'h00000020, 32'h40005013, 3'b001},
        '{5'd7, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 3'b100},
        '{5'd1, 32'h00002023, 32'hFFFFFFFF, 32'hFE002FA3, 3'b000},
        '{5'd2, 32'h00000063, 32'h00001001, 32'h00000063, 3'b011},
        '{5'd0, 32'h00B50533, 32'hFFFFFFFF, 32'h00B50533, 3'b000},
        '{5'd4, 32'h0000006F, 32'hFFF00000, 32'h8000006F, 3'b000}
    };

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the reference model with hand-computed words.
        chk("pin_B", model(5'd2, 32'h63, 32'hFFFFFFFC), {3'b000, 32'hFE000EE3});
        chk("pin_J", model(5'd4, 32'h6F, 32'h800), {3'b000, 32'h0010006F});
        chk("pin_S", model(5'd1, 32'h2023, 32'hFFFFFFFF), {3'b000, 32'hFE002FA3});
        chk("pin_Bodd", model(5'd2, 32'h63, 32'hFFFFF001), {3'b010, 32'h00000063});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            send_one(vecs[i].sel, vecs[i].tmpl, vecs[i].imm, vecs[i].inst, vecs[i].err);
            if (i == 2) chk("err_count_1", 35'(err_count), 35'd1);
        end
        chk("cnt_pre_bp", 35'(err_count), 35'd5);

        // Backpressure: four back-to-back requests while the consumer stalls.
        n_acc = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) push(5'd5, 32'h13 | (i << 7), 32'(i * 3));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("bp_accepted", 35'(n_acc), 35'd2);
                chk("bp_in_ready", 35'(in_ready), 35'd0);
                chk("bp_hold", {out_err, out_inst}, {3'b000, 32'h00000013});
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("bp_total", 35'(n_acc), 35'd4);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        push(5'd7, 32'hAAAA0000, 32'h0);
        push(5'd7, 32'hBBBB0000, 32'h0);
        in_valid = 1'b0;
        chk("pre_rst_valid", 35'(out_valid), 35'd1);
        chk("pre_rst_cnt", 35'(err_count), 35'd5);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 35'(out_valid), 35'd0);
        chk("async_rst_cnt", 35'(err_count), 35'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_quiet", 35'(out_valid), 35'd0);
        end
        @(posedge clk);
        #1;

        // Saturation of the error counter.
        for (int i = 0; i < (2 ** CNT_W) + 2; i++) push(5'd7, 32'(i), 32'h0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("sat", 35'(err_count), 35'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
